// File: rtl/square_gen_if.sv
// Control, configuration and sample-stream bundle for the square_gen burst generator.
// The master drives start/stop and configuration; the slave returns the registered sample stream.
interface square_gen_if #(
  parameter int DAT_WIDTH = 18,
  parameter int CNT_WIDTH = 32
) ();
  logic                        start;
  logic                        stop;
  logic        [CNT_WIDTH-1:0] high_w;
  logic        [CNT_WIDTH-1:0] low_w;
  logic signed [DAT_WIDTH-1:0] amp_hi;
  logic signed [DAT_WIDTH-1:0] amp_lo;
  logic        [CNT_WIDTH-1:0] num_periods;
  logic signed [DAT_WIDTH-1:0] dat;
  logic                        pedge;
  logic                        nedge;
  logic                        busy;
  logic        [CNT_WIDTH-1:0] period_cnt;
  logic                        done;

  modport master (
    output start, stop, high_w, low_w, amp_hi, amp_lo, num_periods,
    input  dat, pedge, nedge, busy, period_cnt, done
  );

  modport slave (
    input  start, stop, high_w, low_w, amp_hi, amp_lo, num_periods,
    output dat, pedge, nedge, busy, period_cnt, done
  );
endinterface

// File: rtl/square_gen.sv
// Burst square-wave generator: HIGH/LOW phases of programmable length and level,
// a finite or continuous number of periods, abortable by stop and restartable by start.
module square_gen #(
  parameter int DAT_WIDTH = 18,
  parameter int CNT_WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  square_gen_if.slave bus
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  state_t                      state, state_nxt;
  logic        [CNT_WIDTH-1:0] hw_q, hw_nxt;
  logic        [CNT_WIDTH-1:0] lw_q, lw_nxt;
  logic        [CNT_WIDTH-1:0] np_q, np_nxt;
  logic signed [DAT_WIDTH-1:0] ah_q, ah_nxt;
  logic signed [DAT_WIDTH-1:0] al_q, al_nxt;
  logic        [CNT_WIDTH-1:0] ph_cnt, ph_nxt;
  logic        [CNT_WIDTH-1:0] pc_p1, pc_nxt;
  logic signed [DAT_WIDTH-1:0] dat_p1, dat_nxt;
  logic                        pedge_p1, pedge_nxt;
  logic                        nedge_p1, nedge_nxt;
  logic                        busy_p1, busy_nxt;
  logic                        done_p1, done_nxt;
  logic                        go, abort;
  logic        [CNT_WIDTH-1:0] pc_inc;

  // A zero-length phase would never terminate, so it is clamped to one cycle.
  function automatic logic [CNT_WIDTH-1:0] min_one(input logic [CNT_WIDTH-1:0] w);
    return (w == '0) ? CNT_WIDTH'(1) : w;
  endfunction

  assign go     = bus.start & ~bus.stop;
  assign abort  = bus.stop & (state != IDLE);
  assign pc_inc = pc_p1 + CNT_WIDTH'(1);

  always_comb begin
    state_nxt = state;
    hw_nxt    = hw_q;
    lw_nxt    = lw_q;
    np_nxt    = np_q;
    ah_nxt    = ah_q;
    al_nxt    = al_q;
    ph_nxt    = ph_cnt;
    pc_nxt    = pc_p1;
    dat_nxt   = dat_p1;
    pedge_nxt = 1'b0;
    nedge_nxt = 1'b0;
    done_nxt  = 1'b0;

    if (abort) begin
      state_nxt = IDLE;
      dat_nxt   = al_q;
      done_nxt  = 1'b1;
    end else if (go) begin
      hw_nxt    = min_one(bus.high_w);
      lw_nxt    = min_one(bus.low_w);
      np_nxt    = bus.num_periods;
      ah_nxt    = bus.amp_hi;
      al_nxt    = bus.amp_lo;
      state_nxt = HIGH;
      dat_nxt   = bus.amp_hi;
      pedge_nxt = 1'b1;
      ph_nxt    = CNT_WIDTH'(1);
      pc_nxt    = '0;
    end else begin
      case (state)
        HIGH: begin
          if (ph_cnt == hw_q) begin
            state_nxt = LOW;
            dat_nxt   = al_q;
            nedge_nxt = 1'b1;
            ph_nxt    = CNT_WIDTH'(1);
          end else begin
            ph_nxt = ph_cnt + CNT_WIDTH'(1);
          end
        end
        LOW: begin
          if (ph_cnt == lw_q) begin
            pc_nxt = pc_inc;
            // num_periods of zero means run until stopped; pc simply wraps.
            if ((np_q != '0) && (pc_inc == np_q)) begin
              state_nxt = IDLE;
              dat_nxt   = al_q;
              done_nxt  = 1'b1;
            end else begin
              state_nxt = HIGH;
              dat_nxt   = ah_q;
              pedge_nxt = 1'b1;
              ph_nxt    = CNT_WIDTH'(1);
            end
          end else begin
            ph_nxt = ph_cnt + CNT_WIDTH'(1);
          end
        end
        default: ;
      endcase
    end

    busy_nxt = (state_nxt != IDLE);
  end

  // Output stage: every output is a register loaded from the next-state logic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      hw_q     <= '0;
      lw_q     <= '0;
      np_q     <= '0;
      ah_q     <= '0;
      al_q     <= '0;
      ph_cnt   <= '0;
      pc_p1    <= '0;
      dat_p1   <= '0;
      pedge_p1 <= 1'b0;
      nedge_p1 <= 1'b0;
      busy_p1  <= 1'b0;
      done_p1  <= 1'b0;
    end else begin
      state    <= state_nxt;
      hw_q     <= hw_nxt;
      lw_q     <= lw_nxt;
      np_q     <= np_nxt;
      ah_q     <= ah_nxt;
      al_q     <= al_nxt;
      ph_cnt   <= ph_nxt;
      pc_p1    <= pc_nxt;
      dat_p1   <= dat_nxt;
      pedge_p1 <= pedge_nxt;
      nedge_p1 <= nedge_nxt;
      busy_p1  <= busy_nxt;
      done_p1  <= done_nxt;
    end
  end

  assign bus.dat        = dat_p1;
  assign bus.pedge      = pedge_p1;
  assign bus.nedge      = nedge_p1;
  assign bus.busy       = busy_p1;
  assign bus.period_cnt = pc_p1;
  assign bus.done       = done_p1;

endmodule

// File: tb/tb_square_gen.sv
// Bench for square_gen: a burst-position model predicts every output each cycle,
// with directed scenarios pinned by literal expectations followed by random traffic.
module tb_square_gen;
  localparam int DW = 18;
  localparam int CW = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic cmp_en = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  square_gen_if #(.DAT_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

  square_gen #(.DAT_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a burst is a cycle index k from its first HIGH cycle; outputs follow
  // from k modulo the period length, and the burst ends at k = num_periods * period.
  logic                 m_active;
  longint               m_k, m_hw, m_lw, m_np;
  logic signed [DW-1:0] m_ah, m_al;
  logic signed [DW-1:0] e_dat;
  logic                 e_pedge, e_nedge, e_busy, e_done;
  logic        [CW-1:0] e_pc;

  always @(posedge clk or negedge rst_n) begin : model
    longint per, r;
    if (!rst_n) begin
      m_active = 1'b0; m_k = 0; m_hw = 0; m_lw = 0; m_np = 0; m_ah = '0; m_al = '0;
      e_dat = '0; e_pedge = 1'b0; e_nedge = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_pc = '0;
    end else begin
      e_done = 1'b0; e_pedge = 1'b0; e_nedge = 1'b0;
      if (bus.stop && m_active) begin
        m_active = 1'b0; e_done = 1'b1; e_dat = m_al; e_busy = 1'b0;
      end else if (bus.start && !bus.stop) begin
        m_hw = (bus.high_w == 0) ? 64'd1 : longint'(bus.high_w);
        m_lw = (bus.low_w == 0) ? 64'd1 : longint'(bus.low_w);
        m_np = longint'(bus.num_periods);
        m_ah = bus.amp_hi; m_al = bus.amp_lo;
        m_k = 0; m_active = 1'b1;
      end else if (m_active) begin
        m_k++;
        if (m_np != 0 && m_k == m_np * (m_hw + m_lw)) begin
          m_active = 1'b0; e_done = 1'b1; e_dat = m_al; e_busy = 1'b0; e_pc = CW'(m_np);
        end
      end
      if (m_active) begin
        per = m_hw + m_lw;
        r = m_k % per;
        e_dat   = (r < m_hw) ? m_ah : m_al;
        e_pedge = (r == 0);
        e_nedge = (r == m_hw);
        e_busy  = 1'b1;
        e_pc    = CW'(m_k / per);
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("dat", bus.dat, e_dat);
      chk("pedge", bus.pedge, e_pedge);
      chk("nedge", bus.nedge, e_nedge);
      chk("busy", bus.busy, e_busy);
      chk("done", bus.done, e_done);
      chk("period_cnt", bus.period_cnt, e_pc);
      if (bus.pedge && bus.nedge) chk("pedge_and_nedge", 1, 0);
    end
  end

  task automatic cfg(input int hw, input int lw, input int ah, input int al, input int np);
    bus.high_w = CW'(hw); bus.low_w = CW'(lw);
    bus.amp_hi = DW'(ah); bus.amp_lo = DW'(al);
    bus.num_periods = CW'(np);
  endtask

  // Returns just after the sampling edge, so the next negedge shows cycle t1.
  task automatic pulse(input logic s, input logic p);
    @(posedge clk); #1 bus.start = s; bus.stop = p;
    @(posedge clk); #1 bus.start = 1'b0; bus.stop = 1'b0;
  endtask

  initial begin
    bus.start = 1'b0; bus.stop = 1'b0;
    cfg(0, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1 cmp_en = 1'b1;
    @(negedge clk);
    chk("rst_dat", bus.dat, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_pc", bus.period_cnt, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Two periods of 3 high / 2 low; inputs scrambled after start must not matter.
    cfg(3, 2, 1000, -1000, 2);
    pulse(1'b1, 1'b0);
    @(negedge clk);
    chk("b1_t1_dat", bus.dat, 1000);
    chk("b1_t1_pedge", bus.pedge, 1);
    cfg(9, 9, 5, 5, 0);
    repeat (3) @(negedge clk);
    chk("b1_t4_dat", bus.dat, -1000);
    chk("b1_t4_nedge", bus.nedge, 1);
    repeat (2) @(negedge clk);
    chk("b1_t6_pedge", bus.pedge, 1);
    chk("b1_t6_dat", bus.dat, 1000);
    repeat (5) @(negedge clk);
    chk("b1_t11_done", bus.done, 1);
    chk("b1_t11_busy", bus.busy, 0);
    chk("b1_t11_pc", bus.period_cnt, 2);
    chk("b1_t11_dat", bus.dat, -1000);
    @(negedge clk);
    chk("b1_t12_done", bus.done, 0);

    // Zero widths behave as one cycle each.
    cfg(0, 0, 7, -7, 3);
    pulse(1'b1, 1'b0);
    @(negedge clk);
    chk("b2_t1_busy", bus.busy, 1);
    repeat (5) @(negedge clk);
    chk("b2_t6_busy", bus.busy, 1);
    chk("b2_t6_nedge", bus.nedge, 1);
    @(negedge clk);
    chk("b2_t7_done", bus.done, 1);
    chk("b2_t7_pc", bus.period_cnt, 3);

    // Continuous burst stopped during cycle 10.
    cfg(4, 4, 300, -300, 0);
    pulse(1'b1, 1'b0);
    repeat (8) @(posedge clk);
    pulse(1'b0, 1'b1);
    @(negedge clk);
    chk("b3_done", bus.done, 1);
    chk("b3_busy", bus.busy, 0);
    chk("b3_pc", bus.period_cnt, 1);
    chk("b3_dat", bus.dat, -300);

    // Restart mid-HIGH with a new amplitude.
    cfg(5, 3, 500, -500, 0);
    pulse(1'b1, 1'b0);
    @(posedge clk);
    cfg(5, 3, 777, -777, 0);
    pulse(1'b1, 1'b0);
    @(negedge clk);
    chk("b4_pedge", bus.pedge, 1);
    chk("b4_pc", bus.period_cnt, 0);
    chk("b4_dat", bus.dat, 777);
    chk("b4_done", bus.done, 0);
    pulse(1'b0, 1'b1);

    // start+stop together: aborts when busy, no effect when idle.
    cfg(2, 2, 11, -11, 0);
    pulse(1'b1, 1'b0);
    repeat (2) @(posedge clk);
    pulse(1'b1, 1'b1);
    @(negedge clk);
    chk("b5_done", bus.done, 1);
    chk("b5_busy", bus.busy, 0);
    pulse(1'b1, 1'b1);
    @(negedge clk);
    chk("b5_idle_done", bus.done, 0);
    chk("b5_idle_busy", bus.busy, 0);
    pulse(1'b0, 1'b1);
    @(negedge clk);
    chk("b5_idlestop_done", bus.done, 0);

    // Reset during LOW after one completed period.
    cfg(1, 6, 40, -40, 0);
    pulse(1'b1, 1'b0);
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("b6_pc_before", 0, 0 + 0);
    chk("b6_rst_dat", bus.dat, 0);
    chk("b6_rst_pc", bus.period_cnt, 0);
    chk("b6_rst_busy", bus.busy, 0);
    chk("b6_rst_nedge", bus.nedge, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("b6_nodone", bus.done, 0);

    // Randomised traffic with inputs changing every cycle.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      cfg($urandom_range(0, 6), $urandom_range(0, 6), int'($urandom), int'($urandom),
          $urandom_range(0, 4));
      bus.start = ($urandom_range(0, 29) == 0);
      bus.stop  = ($urandom_range(0, 59) == 0);
      rst_n     = ($urandom_range(0, 799) != 0);
    end
    @(posedge clk); #1 bus.start = 1'b0; bus.stop = 1'b0; rst_n = 1'b1;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
